// File: rtl/uart_rx_core_if.sv
// RX FIFO push-side bundle of the UART receiver: data/status strobe toward the
// FIFO and LSR overrun pulse, plus the FIFO-full back-pressure flag.
interface uart_rx_core_if;
  logic       rx_push_o;
  logic [7:0] rx_data_o;
  logic       rx_pe_o;
  logic       rx_fe_o;
  logic       rx_bi_o;
  logic       rx_oe_o;
  logic       fifo_full_i;

  modport master (
    output rx_push_o, rx_data_o, rx_pe_o, rx_fe_o, rx_bi_o, rx_oe_o,
    input  fifo_full_i
  );

  modport slave (
    input  rx_push_o, rx_data_o, rx_pe_o, rx_fe_o, rx_bi_o, rx_oe_o,
    output fifo_full_i
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART serial receive engine: oversamples rx on the baud tick, deserialises
// LCR-configured frames and pushes data plus PE/FE/BI status into the RX FIFO.
// Overrun (frame completed while FIFO full) is a separate one-clk pulse.
module uart_rx_core #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active low
  input  logic              baud_tick,
  input  logic              rx_i,
  input  logic [1:0]        wls_i,
  input  logic              pen_i,
  input  logic              eps_i,
  input  logic              sticky_i,
  output logic              rx_busy_o,
  uart_rx_core_if.master    fifo
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [TW-1:0]          tick_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             data_q;
  logic                   par_q;
  logic [1:0]             wls_q;
  logic                   pen_q;
  logic                   eps_q;
  logic                   sticky_q;

  logic                   frame_done;
  logic                   brk;
  logic                   par_exp;
  logic [2:0]             last_idx;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign rx_busy_o = (state_q != IDLE);

  // Input synchroniser; preset to the idle line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and frame-completion flags, evaluated on baud ticks only.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    last_idx   = 3'd4 + {1'b0, wls_q};
    par_exp    = sticky_q ? ~eps_q : (eps_q ? ^data_q : ~^data_q);
    // Break: every data bit, the parity bit (when present) and the stop bit low.
    brk        = (data_q == 8'h00) && !(pen_q && par_q) && !rx_s;
    if (baud_tick) begin
      unique case (state_q)
        IDLE:     if (!rx_s) state_d = START;
        START:    if (tick_cnt == HALF_LAST) state_d = rx_s ? IDLE : DATA;
        DATA:     if (tick_cnt == FULL_LAST && bit_cnt == last_idx)
                    state_d = pen_q ? PARITY : STOP;
        PARITY:   if (tick_cnt == FULL_LAST) state_d = STOP;
        STOP:     if (tick_cnt == FULL_LAST) begin
                    frame_done = 1'b1;
                    state_d    = brk ? BRK_WAIT : IDLE;
                  end
        BRK_WAIT: if (rx_s) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Bit timing counters, shift register, parity sample and latched LCR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      wls_q    <= '0;
      pen_q    <= 1'b0;
      eps_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else if (baud_tick) begin
      unique case (state_q)
        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            data_q   <= '0;
            wls_q    <= wls_i;
            pen_q    <= pen_i;
            eps_q    <= eps_i;
            sticky_q <= sticky_i;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt        <= '0;
            data_q[bit_cnt] <= rx_s;
            bit_cnt         <= bit_cnt + 3'd1;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        PARITY: begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt <= '0;
            par_q    <= rx_s;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (tick_cnt == FULL_LAST) tick_cnt <= '0;
          else                       tick_cnt <= tick_cnt + TW'(1);
        end
        default: tick_cnt <= '0;
      endcase
    end
  end

  // FIFO push / overrun strobes; status registers change only on an actual push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo.rx_push_o <= 1'b0;
      fifo.rx_oe_o   <= 1'b0;
      fifo.rx_data_o <= '0;
      fifo.rx_pe_o   <= 1'b0;
      fifo.rx_fe_o   <= 1'b0;
      fifo.rx_bi_o   <= 1'b0;
    end else begin
      fifo.rx_push_o <= 1'b0;
      fifo.rx_oe_o   <= 1'b0;
      if (frame_done) begin
        if (fifo.fifo_full_i) begin
          fifo.rx_oe_o <= 1'b1;
        end else begin
          fifo.rx_push_o <= 1'b1;
          fifo.rx_data_o <= brk ? 8'h00 : data_q;
          fifo.rx_pe_o   <= pen_q && (par_q != par_exp);
          fifo.rx_fe_o   <= !rx_s;
          fifo.rx_bi_o   <= brk;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frame table, randomized frames
// against a behavioural frame model, plus false-start and mid-frame reset cases.
module tb_uart_rx_core;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx_i = 1'b1;
  logic [1:0] wls_i = 2'b11;
  logic       pen_i = 1'b0;
  logic       eps_i = 1'b0;
  logic       sticky_i = 1'b0;
  logic       rx_busy_o;

  uart_rx_core_if fifo_if ();

  uart_rx_core #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx_i      (rx_i),
    .wls_i     (wls_i),
    .pen_i     (pen_i),
    .eps_i     (eps_i),
    .sticky_i  (sticky_i),
    .rx_busy_o (rx_busy_o),
    .fifo      (fifo_if)
  );

  always #5 clk = ~clk;

  // One-clk tick every second clock.
  initial forever begin
    @(posedge clk);
    #1 baud_tick = ~baud_tick;
  end

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
  } push_t;

  typedef struct {
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sticky;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic       full;
    int         extra;     // extra low bit-times after a low stop bit
    logic       exp_push;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_bi;
    logic       exp_oe;
  } vec_t;

  push_t push_q[$];
  int    oe_cnt = 0;
  int    b2b    = 0;
  bit    prev_push = 1'b0;
  int    chk = 0;
  int    pass = 0;
  logic [7:0] last_data = 8'h00;

  // Capture every push and overrun pulse.
  always @(negedge clk) begin
    push_t p;
    if (fifo_if.rx_push_o === 1'b1) begin
      p.data = fifo_if.rx_data_o;
      p.pe   = fifo_if.rx_pe_o;
      p.fe   = fifo_if.rx_fe_o;
      p.bi   = fifo_if.rx_bi_o;
      push_q.push_back(p);
      if (prev_push) b2b++;
    end
    prev_push = (fifo_if.rx_push_o === 1'b1);
    if (fifo_if.rx_oe_o === 1'b1) oe_cnt++;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    chk++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Frame-level reference: result derived from the line-format rules.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int   n = 5 + int'(v.wls);
    logic [7:0] mask = 8'((1 << n) - 1);
    logic [7:0] d = v.data & mask;
    logic ones_odd = ^d;
    logic want_par = v.sticky ? !v.eps : (v.eps ? ones_odd : !ones_odd);
    r.data     = d;
    r.exp_bi   = (d == 8'h00) && (!v.pen || !v.pbit) && !v.stop;
    r.exp_pe   = v.pen && (v.pbit != want_par);
    r.exp_fe   = !v.stop || r.exp_bi;
    r.exp_data = r.exp_bi ? 8'h00 : d;
    r.exp_push = !v.full;
    r.exp_oe   = v.full;
    return r;
  endfunction

  task automatic wait_ticks(input int n);
    repeat (2 * n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v, input bit scramble);
    wls_i = v.wls; pen_i = v.pen; eps_i = v.eps; sticky_i = v.sticky;
    fifo_if.fifo_full_i = v.full;
    rx_i = 1'b1; wait_ticks(OS);
    rx_i = 1'b0; wait_ticks(OS);
    if (scramble) begin
      wls_i = 2'($urandom); pen_i = 1'($urandom);
      eps_i = 1'($urandom); sticky_i = 1'($urandom);
    end
    for (int i = 0; i < 5 + int'(v.wls); i++) begin
      rx_i = v.data[i]; wait_ticks(OS);
    end
    if (v.pen) begin
      rx_i = v.pbit; wait_ticks(OS);
    end
    rx_i = v.stop;
    if (v.stop)           wait_ticks(OS);
    else if (v.extra == 0) wait_ticks(12);
    else                  wait_ticks(OS * (1 + v.extra));
    rx_i = 1'b1;
    wait_ticks(3 * OS);
    fifo_if.fifo_full_i = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit scramble);
    int n0 = push_q.size();
    int o0 = oe_cnt;
    send_frame(v, scramble);
    check({tag, "_npush"}, push_q.size() - n0, {31'd0, v.exp_push});
    check({tag, "_oe"}, oe_cnt - o0, {31'd0, v.exp_oe});
    if (v.exp_push && push_q.size() > n0) begin
      check({tag, "_data"}, push_q[n0].data, v.exp_data);
      check({tag, "_pe"}, push_q[n0].pe, v.exp_pe);
      check({tag, "_fe"}, push_q[n0].fe, v.exp_fe);
      check({tag, "_bi"}, push_q[n0].bi, v.exp_bi);
      last_data = v.exp_data;
    end else if (!v.exp_push) begin
      check({tag, "_hold"}, fifo_if.rx_data_o, last_data);
    end
    check({tag, "_busy"}, rx_busy_o, 0);
  endtask

  vec_t tbl[10];

  initial begin
    int n0;
    int o0;
    vec_t v;

    //          wls    pen eps st  data   pb st fu ex | push data  pe fe bi oe
    tbl[0] = '{2'b11, 0, 0, 0, 8'hA5, 0, 1, 0, 0, 1, 8'hA5, 0, 0, 0, 0};
    tbl[1] = '{2'b10, 1, 1, 0, 8'h35, 1, 1, 0, 0, 1, 8'h35, 1, 0, 0, 0};
    tbl[2] = '{2'b10, 1, 1, 0, 8'h35, 0, 1, 0, 0, 1, 8'h35, 0, 0, 0, 0};
    tbl[3] = '{2'b00, 1, 1, 1, 8'h1F, 0, 1, 0, 0, 1, 8'h1F, 0, 0, 0, 0};
    tbl[4] = '{2'b00, 1, 1, 1, 8'h1F, 0, 0, 0, 0, 1, 8'h1F, 0, 1, 0, 0};
    tbl[5] = '{2'b11, 0, 0, 0, 8'h00, 0, 0, 0, 2, 1, 8'h00, 0, 1, 1, 0};
    tbl[6] = '{2'b11, 1, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h00, 0, 0, 0, 0};
    tbl[7] = '{2'b00, 1, 1, 0, 8'h00, 0, 0, 0, 1, 1, 8'h00, 0, 1, 1, 0};
    tbl[8] = '{2'b01, 1, 0, 1, 8'h2A, 0, 1, 0, 0, 1, 8'h2A, 1, 0, 0, 0};
    tbl[9] = '{2'b11, 0, 0, 0, 8'h5A, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 1};

    fifo_if.fifo_full_i = 1'b0;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_push", fifo_if.rx_push_o, 0);
    check("rst_data", fifo_if.rx_data_o, 0);
    check("rst_status", {fifo_if.rx_pe_o, fifo_if.rx_fe_o, fifo_if.rx_bi_o, fifo_if.rx_oe_o}, 0);
    check("rst_busy", rx_busy_o, 0);
    rst = 1'b1;
    wait_ticks(4);

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), tbl[i], 1'b0);

    // False start: 4-tick low glitch.
    n0 = push_q.size();
    rx_i = 1'b0; wait_ticks(4);
    check("fs_busy_mid", rx_busy_o, 1);
    rx_i = 1'b1; wait_ticks(30);
    check("fs_npush", push_q.size() - n0, 0);
    check("fs_busy_end", rx_busy_o, 0);

    // Reset asserted mid-frame.
    n0 = push_q.size();
    o0 = oe_cnt;
    wls_i = 2'b11; pen_i = 1'b0;
    rx_i = 1'b0; wait_ticks(3 * OS);
    check("mr_busy_pre", rx_busy_o, 1);
    rst = 1'b0;
    #3;
    check("mr_busy_rst", rx_busy_o, 0);
    rx_i = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    wait_ticks(12 * OS);
    check("mr_npush", push_q.size() - n0, 0);
    check("mr_oe", oe_cnt - o0, 0);
    check("mr_busy_end", rx_busy_o, 0);
    last_data = 8'h00;
    run_vec("post_rst", tbl[0], 1'b0);

    // Randomized frames with mid-frame LCR scrambling.
    for (int i = 0; i < 25; i++) begin
      v = '{default: '0};
      v.wls    = 2'($urandom_range(0, 3));
      v.pen    = 1'($urandom);
      v.eps    = 1'($urandom);
      v.sticky = 1'($urandom);
      v.data   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      v.pbit   = 1'($urandom);
      v.stop   = ($urandom_range(0, 4) != 0);
      v.full   = ($urandom_range(0, 6) == 0);
      v.extra  = 0;
      v = model(v);
      run_vec($sformatf("rnd%0d", i), v, 1'b1);
    end

    check("no_back_to_back", b2b, 0);
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
